// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - DM-priority arbiter sharing one memory port between fetch and load/store
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t              state;
    state_t              state_nxt;
    owner_t              owner;
    owner_t              owner_nxt;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streak_nxt;

    logic grant_if;
    logic grant_dm;
    logic resp;

    // Arbitration in IDLE, response routing in BUSY; nothing happens while reset is high.
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        streak_nxt = streak;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        resp       = 1'b0;
        if (!reset) begin
            if (state == IDLE) begin
                // DM wins ties unless IF has already watched STARVE_LIMIT DM grants go by.
                if (dm_req && !(if_req && streak == STREAK_MAX)) begin
                    grant_dm = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end

                if (grant_dm) begin
                    state_nxt = BUSY;
                    owner_nxt = OWN_DM;
                    if (if_req) begin
                        streak_nxt = (streak == STREAK_MAX) ? streak : streak + STREAK_W'(1);
                    end else begin
                        streak_nxt = '0;
                    end
                end else if (grant_if) begin
                    state_nxt  = BUSY;
                    owner_nxt  = OWN_IF;
                    streak_nxt = '0;
                end
            end else begin
                // Only a response seen while a transaction is outstanding counts.
                if (mem_rvalid) begin
                    resp      = 1'b1;
                    state_nxt = IDLE;
                end
            end
        end
    end

    // State, owner and starvation streak registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= OWN_IF;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            streak <= streak_nxt;
        end
    end

    assign if_gnt    = grant_if;
    assign dm_gnt    = grant_dm;
    assign mem_req   = grant_if | grant_dm;
    assign mem_we    = grant_dm & dm_we;
    assign mem_addr  = grant_dm ? dm_addr  : (grant_if ? if_addr : '0);
    assign mem_wdata = grant_dm ? dm_wdata : '0;

    assign if_rvalid = resp && (owner == OWN_IF);
    assign dm_rvalid = resp && (owner == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with randomized requesters and memory
module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        bit          is_dm;
        bit          is_store;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] rd_store(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // knobs
    int if_pct = 0, dm_pct = 0, spur_pct = 0, rst_per = 0, lat_min = 1, lat_max = 1;
    bit hold_both = 0, fix_if = 0, fix_dm = 0, force_rst = 1, trace_on = 0;

    // shared between drivers and monitor
    bit          saw_if_gnt = 0, saw_dm_gnt = 0;
    bit          mem_pend = 0, pend_we = 0, stale = 0;
    logic [31:0] pend_addr = '0;
    int          mem_lat = 0;
    int          cyc = 0;
    bit          trace_dm[$];
    int          trace_cyc[$];

    // reference model state
    bit m_busy = 0, m_owner_dm = 0;
    int m_streak = 0;

    // Monitor + scoreboard + memory command capture, all sampled away from the rising edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   resp_exp, exp_dm, exp_if;
        cyc++;
        saw_if_gnt = if_gnt;
        saw_dm_gnt = dm_gnt;
        if (reset) begin
            check("rst_if_gnt", 32'(if_gnt), 0);
            check("rst_dm_gnt", 32'(dm_gnt), 0);
            check("rst_mem_req", 32'(mem_req), 0);
            check("rst_if_rvalid", 32'(if_rvalid), 0);
            check("rst_dm_rvalid", 32'(dm_rvalid), 0);
            check("rst_mem_addr", mem_addr, 0);
            m_busy   = 0;
            m_streak = 0;
            exp_q.delete();
            if (mem_pend) stale = 1;
            mem_pend = 0;
        end else begin
            resp_exp = m_busy && mem_rvalid;
            if (resp_exp || if_rvalid || dm_rvalid) begin
                if (!resp_exp) begin
                    check("unexpected_rvalid", {30'd0, if_rvalid, dm_rvalid}, 0);
                end else if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("if_rvalid", 32'(if_rvalid), 32'(!e.is_dm));
                    check("dm_rvalid", 32'(dm_rvalid), 32'(e.is_dm));
                    if (!e.is_store) check(e.is_dm ? "dm_rdata" : "if_rdata", e.is_dm ? dm_rdata : if_rdata, e.data);
                end
            end
            if (m_busy && m_owner_dm)  check("if_rdata_nonowner", if_rdata, 0);
            if (m_busy && !m_owner_dm) check("dm_rdata_nonowner", dm_rdata, 0);

            exp_dm = !m_busy && dm_req && !(if_req && m_streak == LIM);
            exp_if = !m_busy && if_req && !exp_dm;
            check("if_gnt", 32'(if_gnt), 32'(exp_if));
            check("dm_gnt", 32'(dm_gnt), 32'(exp_dm));
            check("mem_req", 32'(mem_req), 32'(exp_dm || exp_if));
            if (exp_dm) begin
                check("mem_we_dm", 32'(mem_we), 32'(dm_we));
                check("mem_addr_dm", mem_addr, dm_addr);
                if (dm_we) check("mem_wdata_dm", mem_wdata, dm_wdata);
            end else if (exp_if) begin
                check("mem_we_if", 32'(mem_we), 0);
                check("mem_addr_if", mem_addr, if_addr);
            end else begin
                check("mem_addr_idle", mem_addr, 0);
                check("mem_wdata_idle", mem_wdata, 0);
            end

            if (resp_exp) m_busy = 0;
            if (exp_dm) begin
                e.is_dm = 1; e.is_store = dm_we; e.data = rd_ref(dm_addr);
                exp_q.push_back(e);
                if (dm_we) ref_mem[dm_addr] = dm_wdata;
                m_streak   = if_req ? ((m_streak < LIM) ? m_streak + 1 : LIM) : 0;
                m_busy     = 1;
                m_owner_dm = 1;
            end else if (exp_if) begin
                e.is_dm = 0; e.is_store = 0; e.data = rd_ref(if_addr);
                exp_q.push_back(e);
                m_streak   = 0;
                m_busy     = 1;
                m_owner_dm = 0;
            end

            if (mem_req) begin
                if (mem_we) mem_store[mem_addr] = mem_wdata;
                mem_pend  = 1;
                pend_we   = mem_we;
                pend_addr = mem_addr;
                mem_lat   = $urandom_range(lat_min, lat_max);
            end
            if (trace_on && (if_gnt || dm_gnt)) begin
                trace_dm.push_back(dm_gnt);
                trace_cyc.push_back(cyc);
            end
        end
    end

    function automatic logic [31:0] rnd_addr();
        return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    endfunction

    // Drives reset, both requesters and the memory responder once per cycle, just after the edge.
    task automatic drive_cycle();
        reset = force_rst || (rst_per > 0 && $urandom_range(1, rst_per) == 1);

        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (reset) begin
            mem_rvalid = 1'($urandom_range(0, 1));
        end else if (stale) begin
            mem_rvalid = 1'b1;
            stale      = 0;
        end else if (mem_pend) begin
            mem_lat--;
            if (mem_lat <= 0) begin
                mem_rvalid = 1'b1;
                if (!pend_we) mem_rdata = rd_store(pend_addr);
                mem_pend = 0;
            end
        end else if ($urandom_range(0, 99) < spur_pct) begin
            mem_rvalid = 1'b1;
        end

        if (if_req && saw_if_gnt) begin
            if (hold_both || (if_pct > 0 && $urandom_range(0, 1) == 1)) begin
                if_addr = fix_if ? 32'h10 : rnd_addr();
            end else begin
                if_req = 1'b0;
            end
        end else if (!if_req && (hold_both || $urandom_range(0, 99) < if_pct)) begin
            if_req  = 1'b1;
            if_addr = fix_if ? 32'h10 : rnd_addr();
        end

        if ((dm_req && saw_dm_gnt && (hold_both || (dm_pct > 0 && $urandom_range(0, 1) == 1))) ||
            (!dm_req && (hold_both || $urandom_range(0, 99) < dm_pct))) begin
            dm_req   = 1'b1;
            dm_we    = fix_dm ? 1'b1 : 1'($urandom_range(0, 1));
            dm_addr  = fix_dm ? 32'h200 : rnd_addr();
            dm_wdata = fix_dm ? 32'h55 : $urandom;
        end else if (dm_req && saw_dm_gnt) begin
            dm_req = 1'b0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive_cycle();
        end
    endtask

    initial begin
        logic [9:0] pat;
        reset = 1'b1; if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b1;
        dm_addr = 32'h4; dm_wdata = 32'h1; mem_rvalid = 1'b1; mem_rdata = 32'h0;
        mem_store[32'h10] = 32'hDEADBEEF;
        ref_mem[32'h10]   = 32'hDEADBEEF;
        run(3);

        // drop requests, release reset
        force_rst = 0; if_req = 1'b0; dm_req = 1'b0;
        // IF only, fixed address, latency 2
        if_pct = 100; dm_pct = 0; lat_min = 2; lat_max = 2; fix_if = 1;
        run(15);
        // DM stores only
        if_pct = 0; dm_pct = 100; fix_if = 0; fix_dm = 1; lat_min = 1; lat_max = 3;
        run(15);
        fix_dm = 0; dm_pct = 0;
        run(10);

        // contention from a clean reset, latency 1
        force_rst = 1; hold_both = 1; lat_min = 1; lat_max = 1;
        run(2);
        force_rst = 0; trace_on = 1;
        run(30);
        trace_on = 0; hold_both = 0;
        check("contention_count", 32'(trace_dm.size() >= 10), 1);
        pat = 10'b0111101111;
        for (int i = 0; i < 10 && i < trace_dm.size(); i++) check("contention_order", 32'(trace_dm[i]), 32'(pat[i]));
        for (int i = 1; i < trace_cyc.size(); i++) check("turnaround", trace_cyc[i] - trace_cyc[i-1], 2);
        run(10);

        // spurious responses with no requesters
        spur_pct = 50;
        run(20);

        // randomized traffic with occasional resets
        if_pct = 40; dm_pct = 40; spur_pct = 10; lat_min = 1; lat_max = 4; rst_per = 150;
        run(3000);

        // drain
        if_pct = 0; dm_pct = 0; spur_pct = 0; rst_per = 0;
        run(30);
        check("drain_scoreboard", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester (IF) and the load/store requester (DM).
- Sits between the CPU's fetch and data-memory paths and a unified memory with variable response latency.
- Allows one outstanding transaction at a time.
- DM has priority, with a starvation guard so that IF is never locked out indefinitely.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, number of consecutive DM grants made while IF waits before IF is forced to win (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request; held until if_gnt.
- if_addr  input  ADDR_W  fetch address; stable while if_req.
- if_gnt  output  1  one-cycle pulse: fetch accepted this cycle.
- if_rvalid  output  1  one-cycle pulse: fetch data valid.
- if_rdata  output  DATA_W  fetch data; valid with if_rvalid.
- dm_req  input  1  data request; held until dm_gnt.
- dm_we  input  1  1 = store, 0 = load.
- dm_addr  input  ADDR_W  data address.
- dm_wdata  input  DATA_W  store data.
- dm_gnt  output  1  one-cycle pulse: data request accepted.
- dm_rvalid  output  1  one-cycle pulse: load data valid, or store acknowledged.
- dm_rdata  output  DATA_W  load data; don't-care on a store acknowledge.
- mem_req  output  1  memory command strobe, one cycle per transaction.
- mem_we  output  1  write enable, qualified by mem_req.
- mem_addr  output  ADDR_W  memory address, qualified by mem_req.
- mem_wdata  output  DATA_W  memory write data.
- mem_rvalid  input  1  memory response (read data or write ack); arrives ≥1 cycle after mem_req.
- mem_rdata  input  DATA_W  memory read data.

Behaviour:
- State machine: IDLE, BUSY. Registers: state, owner (IF/DM), streak counter of width $clog2(STARVE_LIMIT+1).
- Reset values: state = IDLE, owner = IF, streak = 0.
- While reset is high, all of the following are forced to 0 combinationally: if_gnt, dm_gnt, mem_req, if_rvalid, dm_rvalid.
- mem_addr and mem_wdata are 0 when mem_req is 0.

Arbitration, IDLE only:
- Only DM requesting → grant DM.
- Only IF requesting → grant IF.
- Both requesting → grant DM unless streak == STARVE_LIMIT, in which case grant IF.

Issue, same cycle as grant:
- The grant pulse, mem_req, mem_we and mem_addr/mem_wdata are driven combinationally from the winning requester.
- mem_we = dm_we for DM; 0 for IF.
- Next state is BUSY, with owner = winner.

Streak counter:
- On a DM grant with if_req high: increment, saturating at STARVE_LIMIT.
- On an IF grant: clear to 0.
- On a DM grant with if_req low: clear to 0.
- Otherwise: hold.

BUSY:
- No grants are made, and mem_req = 0.
- On mem_rvalid, the owner's rvalid pulses combinationally, with rdata = mem_rdata; next state is IDLE.
- A new grant is possible no earlier than the cycle after the response, so the minimum turnaround is 2 cycles per transaction.
- The non-owner's rvalid stays 0. The non-owner's rdata is driven 0.

Boundary conditions:
- mem_rvalid in IDLE is spurious: ignore it, with no rvalid to either requester.
- Requests arriving in the mem_rvalid cycle wait until IDLE.
- Reset mid-transaction returns to IDLE and clears streak. A late mem_rvalid after reset is ignored.
- A request held across multiple cycles gets exactly one grant.
- The requester must deassert req, or present a new request, in the cycle after gnt. A still-high req is treated as a new request.

Test Plan:
- Reset, then IF only: if_req = 1 with if_addr = 0x10; memory responds 2 cycles later with 0xDEADBEEF → if_gnt pulse at cycle 0 with mem_addr = 0x10, mem_we = 0; if_rvalid with if_rdata = 0xDEADBEEF at cycle 2; next grant no earlier than cycle 3.
- DM store: dm_req = 1, dm_we = 1, dm_addr = 0x200, dm_wdata = 0x55 → mem_req, mem_we = 1, mem_wdata = 0x55 in the grant cycle; dm_rvalid on the ack; if_rvalid stays 0.
- Contention with STARVE_LIMIT = 4: if_req and dm_req held continuously, 1-cycle memory latency → grant order DM, DM, DM, DM, IF, DM, ...; streak reaches 4 and then clears after the IF grant.
- Simultaneous requests from idle with streak = 0 → DM wins; if_gnt stays low until after DM's response.
- Reset asserted in BUSY, then mem_rvalid arrives in the first cycle after reset → no rvalid to either requester; state IDLE; next if_req granted immediately.
- Spurious mem_rvalid in IDLE with no requests → both rvalid outputs and both grants stay 0; streak unchanged.
